s_burst_ctrl: RTL and testbench

S_BURST_CTRL -- requirements
Module: s_burst_ctrl

---
 rtl/s_burst_ctrl.sv | 141 ++++++++++++++
 tb/tb_s_burst_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/s_burst_ctrl.sv
// s_burst_ctrl
//
// Purpose:
//   Runs one burst of (size + 1) beats between an upstream and a downstream
//   valid/ready port, and then gives a one-cycle done pulse. A burst starts
//   with start in IDLE. The burst length comes from size, which is sampled
//   together with start. Beats pass straight through with zero latency: the
//   controller only gates the handshake and tracks the beat index.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   begin one burst (sampled only in IDLE)
//   size       in   [SIZECOUNT-1:0] burst length minus one (sampled with start)
//   in_valid   in   upstream beat available
//   in_ready   out  upstream beat accepted (out_ready gated by RUN)
//   out_valid  out  downstream beat presented (in_valid gated by RUN)
//   out_ready  in   downstream can accept
//   out_last   out  current beat is the final beat of the burst
//   count      out  [SIZECOUNT-1:0] 0-based index of the current beat
//   busy       out  high while in RUN
//   done       out  one-cycle pulse after the final beat
//   abort      in   only present when S_BURST_CTRL_ABORT_EN is defined;
//                   drops the burst in RUN, with no beat and no done pulse
//
// Build option:
//   S_BURST_CTRL_ABORT_EN  adds the abort input. When it is not defined, a
//                          burst ends only when it completes or on reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; size is captured when start is seen
// RUN   | passing beats; count advances on each handshake
// DONE  | single cycle with done=1; start ignored; back to IDLE next

module s_burst_ctrl #(
    parameter int SIZECOUNT = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SIZECOUNT-1:0] size,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [SIZECOUNT-1:0] count,
    output logic                 busy,
    output logic                 done
`ifdef S_BURST_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SIZECOUNT-1:0] ONE = {{(SIZECOUNT-1){1'b0}}, 1'b1};

    state_t               state_q, state_n;
    logic [SIZECOUNT-1:0] count_q, count_n;
    logic [SIZECOUNT-1:0] size_q,  size_n;

    logic in_run;
    logic kill;
    logic at_last;
    logic beat;

    assign in_run  = (state_q == RUN);
    assign at_last = (count_q == size_q);

`ifdef S_BURST_CTRL_ABORT_EN
    // abort matters only in RUN. It blocks the handshake in the same cycle.
    assign kill = in_run & abort;
`else
    assign kill = 1'b0;
`endif

    assign beat      = in_run & in_valid & out_ready & ~kill;
    assign in_ready  = in_run & out_ready & ~kill;
    assign out_valid = in_run & in_valid & ~kill;
    assign out_last  = in_run & at_last & ~kill;
    assign count     = count_q;
    assign busy      = in_run;
    assign done      = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            size_q  <= size_n;
        end
    end

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        size_n  = size_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    size_n  = size;
                    count_n = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    count_n = '0;
                    state_n = IDLE;
                end else if (beat) begin
                    // The final beat goes to DONE before count could wrap,
                    // so a full-range size still gives 2^SIZECOUNT beats.
                    if (at_last) begin
                        count_n = '0;
                        state_n = DONE;
                    end else begin
                        count_n = count_q + ONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_s_burst_ctrl.sv
module tb_s_burst_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] size;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         abort;

    int passed = 0;
    int total  = 0;

    // Reference model: a burst is a list of beats numbered 0..len-1.
    bit m_active;
    bit m_done;
    int m_idx;
    int m_len;

    s_burst_ctrl #(.SIZECOUNT(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .count     (count),
        .busy      (busy),
        .done      (done)
`ifdef S_BURST_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_idx    = 0;
        m_len    = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit ab;
        ab = m_active & abort;
        chk({tag, ":busy"},      32'(busy),      32'(m_active));
        chk({tag, ":done"},      32'(done),      32'(m_done));
        chk({tag, ":in_ready"},  32'(in_ready),  32'(m_active & out_ready & ~ab));
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_active & in_valid & ~ab));
        chk({tag, ":out_last"},  32'(out_last),  32'(m_active & (m_idx == m_len - 1) & ~ab));
        chk({tag, ":count"},     32'(count),     m_active ? 32'(m_idx) : 32'd0);
    endtask

    task automatic model_step();
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_idx    = 0;
                m_len    = int'(size) + 1;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (in_valid && out_ready) begin
            if (m_idx == m_len - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_idx    = 0;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic cyc(input string tag, input logic st, input logic [W-1:0] sz,
                       input logic iv, input logic ordy);
        start     = st;
        size      = sz;
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        size      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b0;
        model_reset();

        #2;
        check_outputs("por");
        @(posedge clk);
        #1;
        do_reset();
        cyc("idle_inputs", 1'b0, 4'd9, 1'b1, 1'b1);

        // size=3, continuous handshake: 4 beats, then done.
        cyc("s3_start", 1'b1, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc("s3_run", 1'b0, 4'd0, 1'b1, 1'b1);

        // size=0: one beat, out_last on the first beat.
        cyc("s0_start", 1'b1, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("s0_run", 1'b0, 4'd0, 1'b1, 1'b1);

        // size=5, out_ready toggling every cycle.
        cyc("s5_start", 1'b1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) cyc("s5_toggle", 1'b0, 4'd0, 1'b1, logic'(i % 2 == 0));

        // start held high with size changing: each burst keeps its start size.
        for (int i = 0; i < 16; i++) cyc("start_held", 1'b1, 4'(2 + i), 1'b1, 1'b1);
        cyc("start_held_end", 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("start_held_end", 1'b0, 4'd0, 1'b1, 1'b1);
        cyc("start_held_end", 1'b0, 4'd0, 1'b1, 1'b1);

        // Full-range size: 16 beats, count must not wrap.
        cyc("smax_start", 1'b1, 4'd15, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) cyc("smax_run", 1'b0, 4'd0, 1'b1, 1'b1);

        // Reset at count=2 of a size=7 burst, then a full 8-beat burst.
        cyc("s7_start", 1'b1, 4'd7, 1'b1, 1'b1);
        cyc("s7_run", 1'b0, 4'd0, 1'b1, 1'b1);
        cyc("s7_run", 1'b0, 4'd0, 1'b1, 1'b1);
        chk("s7_model_at_2", 32'(m_idx), 32'd2);
        do_reset();
        for (int i = 0; i < 3; i++) cyc("post_rst_idle", 1'b0, 4'd0, 1'b1, 1'b1);
        cyc("s7_again", 1'b1, 4'd7, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc("s7_again_run", 1'b0, 4'd0, 1'b1, 1'b1);

`ifdef S_BURST_CTRL_ABORT_EN
        // abort at count=1 of size=4: no beat, back to IDLE, no done.
        cyc("ab_start", 1'b1, 4'd4, 1'b1, 1'b1);
        cyc("ab_run", 1'b0, 4'd0, 1'b1, 1'b1);
        abort = 1'b1;
        cyc("ab_hit", 1'b0, 4'd0, 1'b1, 1'b1);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) cyc("ab_after", 1'b0, 4'd0, 1'b1, 1'b1);
        abort = 1'b1;
        cyc("ab_in_idle", 1'b1, 4'd1, 1'b1, 1'b1);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) cyc("ab_idle_burst", 1'b0, 4'd0, 1'b1, 1'b1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
`ifdef S_BURST_CTRL_ABORT_EN
            abort = ($urandom_range(0, 31) == 0);
`endif
            cyc("rand",
                logic'($urandom_range(0, 3) == 0),
                W'($urandom_range(0, 15)),
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 3) != 0));
        end
        abort = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
